// File: rtl/awgn_pkg.sv
// Shared constants and types for the taus88-based uniform source of the AWGN chain:
// default seeds, component minima, FSM states and the taus88 shift/mask constants.
package awgn_pkg;

  localparam logic [31:0] SEED_A0 = 32'd12345;
  localparam logic [31:0] SEED_A1 = 32'd67890;
  localparam logic [31:0] SEED_A2 = 32'd13579;
  localparam logic [31:0] SEED_B0 = 32'd24680;
  localparam logic [31:0] SEED_B1 = 32'd11111;
  localparam logic [31:0] SEED_B2 = 32'd99991;

  // A component below its minimum degenerates the generator to a short cycle.
  localparam logic [31:0] MIN_S0 = 32'd2;
  localparam logic [31:0] MIN_S1 = 32'd8;
  localparam logic [31:0] MIN_S2 = 32'd16;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_LOAD   = 2'd2
  } urng_state_t;

  localparam int S0_SHL_A = 13;
  localparam int S0_SHR   = 19;
  localparam int S0_SHL_B = 12;
  localparam logic [31:0] S0_MASK = 32'hFFFF_FFFE;
  localparam int S1_SHL_A = 2;
  localparam int S1_SHR   = 25;
  localparam int S1_SHL_B = 4;
  localparam logic [31:0] S1_MASK = 32'hFFFF_FFF8;
  localparam int S2_SHL_A = 3;
  localparam int S2_SHR   = 11;
  localparam int S2_SHL_B = 17;
  localparam logic [31:0] S2_MASK = 32'hFFFF_FFF0;

  // Seed word index: 0-2 = generator A s0..s2, 3-5 = generator B s0..s2.
  function automatic logic [31:0] default_seed(input logic [2:0] idx);
    logic [31:0] seed;
    case (idx)
      3'd0:    seed = SEED_A0;
      3'd1:    seed = SEED_A1;
      3'd2:    seed = SEED_A2;
      3'd3:    seed = SEED_B0;
      3'd4:    seed = SEED_B1;
      3'd5:    seed = SEED_B2;
      default: seed = 32'd0;
    endcase
    return seed;
  endfunction

  function automatic logic [31:0] min_seed(input logic [2:0] idx);
    logic [31:0] lim;
    case (idx)
      3'd0, 3'd3: lim = MIN_S0;
      3'd1, 3'd4: lim = MIN_S1;
      default:    lim = MIN_S2;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/taus88.sv
// One combinational taus88 step: 96-bit state {s2, s1, s0} in, next state and
// the 32-bit output (XOR of the three next components) out.
module taus88
  import awgn_pkg::*;
(
  input  logic [95:0] state,
  output logic [95:0] state_next,
  output logic [31:0] out
);

  logic [31:0] s0, s1, s2;
  logic [31:0] t0, t1, t2;
  logic [31:0] n0, n1, n2;

  assign s0 = state[31:0];
  assign s1 = state[63:32];
  assign s2 = state[95:64];

  assign t0 = ((s0 << S0_SHL_A) ^ s0) >> S0_SHR;
  assign t1 = ((s1 << S1_SHL_A) ^ s1) >> S1_SHR;
  assign t2 = ((s2 << S2_SHL_A) ^ s2) >> S2_SHR;

  assign n0 = ((s0 & S0_MASK) << S0_SHL_B) ^ t0;
  assign n1 = ((s1 & S1_MASK) << S1_SHL_B) ^ t1;
  assign n2 = ((s2 & S2_MASK) << S2_SHL_B) ^ t2;

  assign state_next = {n2, n1, n0};
  assign out        = n0 ^ n1 ^ n2;

endmodule

// File: rtl/taus_urng.sv
// Dual taus88 uniform generator with seed loading and warm-up sequencing.
// Optional macro TAUS_URNG_SEED_CHECK_EN replaces below-minimum seed words by defaults.
module taus_urng
  import awgn_pkg::*;
#(
  parameter int WARMUP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        seed_we,
  input  logic [2:0]  seed_addr,
  input  logic [31:0] seed_data,
  input  logic        seed_start,
  output logic [47:0] u0,
  output logic [15:0] u1,
  output logic        valid
);

  localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);

  logic [31:0] comp_reg  [6];
  logic [31:0] comp_next [6];
  urng_state_t state_reg, state_next;
  logic [7:0]  count_reg, count_next;

  logic [95:0] a_state, b_state, a_step, b_step;
  logic [31:0] a_out, b_out;
  logic        seed_wr, do_step, run_step;
  logic [31:0] seed_word;

  assign a_state = {comp_reg[2], comp_reg[1], comp_reg[0]};
  assign b_state = {comp_reg[5], comp_reg[4], comp_reg[3]};

  taus88 u_gen_a (.state(a_state), .state_next(a_step), .out(a_out));
  taus88 u_gen_b (.state(b_state), .state_next(b_step), .out(b_out));

  // Seed writes and restarts take the cycle; the generators only step otherwise.
  assign seed_wr  = seed_we && (seed_addr < 3'd6);
  assign do_step  = !seed_wr && !seed_start &&
                    ((state_reg == ST_WARMUP) || ((state_reg == ST_RUN) && en));
  assign run_step = !seed_wr && !seed_start && (state_reg == ST_RUN) && en;

`ifdef TAUS_URNG_SEED_CHECK_EN
  assign seed_word = (seed_data < min_seed(seed_addr)) ? default_seed(seed_addr) : seed_data;
`else
  assign seed_word = seed_data;
`endif

  for (genvar gi = 0; gi < 6; gi++) begin : g_comp
    localparam logic [2:0] IDX = 3'(gi);
    logic [31:0] step_word;
    if (gi < 3) begin : g_a
      assign step_word = a_step[32*gi +: 32];
    end else begin : g_b
      assign step_word = b_step[32*(gi-3) +: 32];
    end
    assign comp_next[gi] = (seed_wr && (seed_addr == IDX)) ? seed_word :
                           do_step                          ? step_word : comp_reg[gi];
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (seed_start) begin
      state_next = ST_WARMUP;
      count_next = 8'd0;
    end else if (seed_wr) begin
      state_next = ST_LOAD;
    end else if (state_reg == ST_WARMUP) begin
      count_next = count_reg + 8'd1;
      if (count_reg == WARM_LAST) state_next = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) comp_reg[i] <= default_seed(3'(i));
      state_reg <= ST_WARMUP;
      count_reg <= 8'd0;
      u0        <= 48'd0;
      u1        <= 16'd0;
      valid     <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) comp_reg[i] <= comp_next[i];
      state_reg <= state_next;
      count_reg <= count_next;
      valid     <= run_step;
      if (run_step) begin
        u0 <= {a_out, b_out[31:16]};
        u1 <= b_out[15:0];
      end
    end
  end

endmodule
